// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution slice: op codes and default sizing.
package alu_pkg;

  localparam int unsigned ALU_DEPTH = 4;
  localparam int unsigned ALU_TAG_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. cout is the adder carry for ADD/SUB (SUB: 1 = no borrow), else 0.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  control,
  output logic [31:0] dout,
  output logic        cout
);

  logic [32:0] sum;
  logic [32:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} + {1'b0, ~b} + 33'd1;
    dout = '0;
    cout = 1'b0;
    unique case (alu_op_e'(control))
      ALU_ADD: {cout, dout} = sum;
      ALU_SUB: {cout, dout} = diff;
      ALU_AND: dout = a & b;
      ALU_OR:  dout = a | b;
      ALU_XOR: dout = a ^ b;
      ALU_SLT: dout = {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: dout = a << b[4:0];
      ALU_SRL: dout = a >> b[4:0];
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Two-edge ALU execution stage: one operand register feeding the alu, then an inline result FIFO
// with ready/valid handshakes on both sides and a per-request sequence tag.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = ALU_DEPTH,
  parameter int unsigned TAG_W = ALU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_cout,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic             live_q;
  logic             s1_valid_q;
  logic [31:0]      s1_a_q;
  logic [31:0]      s1_b_q;
  logic [2:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [TAG_W-1:0] tag_q;
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0]      mem_data [DEPTH];
  logic             mem_cout [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];

  logic [31:0]      alu_dout;
  logic             alu_cout;
  logic             accept;
  logic             push;
  logic             pop;

  alu u_alu (
    .a       (s1_a_q),
    .b       (s1_b_q),
    .control (s1_op_q),
    .dout    (alu_dout),
    .cout    (alu_cout)
  );

  // Ready counts the stage-1 slot as occupied, so a stage-1 push can never overflow the FIFO.
  // live_q holds ready low until the first edge after reset release.
  always_comb begin
    req_ready = live_q && ((CNT_W'(s1_valid_q) + count_q) < CNT_W'(DEPTH));
    rsp_valid = (count_q != '0);
    rsp_data  = rsp_valid ? mem_data[rptr_q] : '0;
    rsp_cout  = rsp_valid ? mem_cout[rptr_q] : 1'b0;
    rsp_tag   = rsp_valid ? mem_tag[rptr_q]  : '0;
    accept    = req_valid && req_ready;
    push      = s1_valid_q;
    pop       = rsp_valid && rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      tag_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      live_q     <= 1'b1;
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q   <= req_a;
        s1_b_q   <= req_b;
        s1_op_q  <= req_op;
        s1_tag_q <= tag_q;
        tag_q    <= tag_q + TAG_W'(1);
      end
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr_q] <= alu_dout;
      mem_cout[wptr_q] <= alu_cout;
      mem_tag[wptr_q]  <= s1_tag_q;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed and randomised bench for alu_exec with a queue scoreboard and an arithmetic ALU model.
module tb_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_cout;
  logic [7:0]  rsp_tag;

  typedef struct {
    logic [31:0] data;
    logic        cout;
    logic [7:0]  tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mtag;
  logic [7:0] last_pop_tag;
  int         passed;
  int         total;

  alu_exec #(.DEPTH(4), .TAG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_tag   (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Result {cout, data} from the op code's arithmetic meaning.
  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] s;
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0: begin s = {32'b0, a} + {32'b0, b}; return s[32:0]; end
      3'd1: return {a >= b, a - b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return (sa < sb) ? 33'd1 : 33'd0;
      3'd6: return {1'b0, a << b[4:0]};
      default: return {1'b0, a >> b[4:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // One clock: sample handshakes before the edge, score pops, advance, settle #1.
  task automatic step(output bit acc);
    bit          pop;
    bit          hold;
    logic [31:0] h_data;
    logic        h_cout;
    logic [7:0]  h_tag;
    exp_t        e;
    logic [32:0] r;
    acc    = req_valid && req_ready;
    pop    = rsp_valid && rsp_ready;
    hold   = rsp_valid && !rsp_ready;
    h_data = rsp_data;
    h_cout = rsp_cout;
    h_tag  = rsp_tag;
    if (pop) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 64'(rsp_data), 64'(e.data));
        chk("sb_cout", 64'(rsp_cout), 64'(e.cout));
        chk("sb_tag", 64'(rsp_tag), 64'(e.tag));
        last_pop_tag = rsp_tag;
      end
    end
    if (acc) begin
      r = ref_alu(req_op, req_a, req_b);
      exp_q.push_back('{data: r[31:0], cout: r[32], tag: mtag});
      mtag++;
    end
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_data", 64'(rsp_data), 64'(h_data));
      chk("hold_cout", 64'(rsp_cout), 64'(h_cout));
      chk("hold_tag", 64'(rsp_tag), 64'(h_tag));
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    mtag = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(acc);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_rsp_valid", 64'(rsp_valid), 64'(0));
  endtask

  task automatic set_rand_req();
    req_a  = $urandom;
    req_b  = $urandom;
    req_op = 3'($urandom_range(0, 7));
  endtask

  initial begin
    bit acc;
    int n;
    passed    = 0;
    total     = 0;
    mtag      = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;

    // Reset values and ready release timing
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
    chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("rel_ready_after_edge", 64'(req_ready), 64'(1));

    // Single ADD, two-edge latency
    req_a = 32'h5; req_b = 32'h3; req_op = 3'b000; req_valid = 1'b1; rsp_ready = 1'b1;
    step(acc);
    chk("add_acc", 64'(acc), 64'(1));
    req_valid = 1'b0;
    chk("add_not_yet", 64'(rsp_valid), 64'(0));
    step(acc);
    chk("add_valid", 64'(rsp_valid), 64'(1));
    chk("add_data", 64'(rsp_data), 64'(32'h8));
    chk("add_cout", 64'(rsp_cout), 64'(0));
    chk("add_tag", 64'(rsp_tag), 64'(0));
    step(acc);

    // Carry out
    req_a = 32'hFFFF_FFFF; req_b = 32'h1; req_op = 3'b000; req_valid = 1'b1;
    step(acc);
    req_valid = 1'b0;
    step(acc);
    chk("carry_data", 64'(rsp_data), 64'(0));
    chk("carry_cout", 64'(rsp_cout), 64'(1));
    chk("carry_tag", 64'(rsp_tag), 64'(1));
    drain();

    // Backpressure: only DEPTH requests fit
    do_reset();
    rsp_ready = 1'b0;
    n = 0;
    req_op = 3'b000; req_b = '0; req_a = 32'd1; req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(acc);
      if (acc) begin
        n++;
        req_a = 32'(n + 1);
      end
    end
    chk("bp_accepted", 64'(n), 64'(4));
    chk("bp_ready_low", 64'(req_ready), 64'(0));
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_data", 64'(rsp_data), 64'(k + 1));
      chk("bp_tag", 64'(rsp_tag), 64'(k));
      step(acc);
    end
    chk("bp_ready_high", 64'(req_ready), 64'(1));
    drain();

    // Full rate: 300 back-to-back requests, tags wrap
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      set_rand_req();
      step(acc);
      if (acc) n++;
    end
    chk("fr_accepts", 64'(n), 64'(300));
    drain();
    chk("fr_last_tag", 64'(last_pop_tag), 64'(43));

    // Reset mid-flight discards everything
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rand_req();
      step(acc);
      chk("mf_acc", 64'(acc), 64'(1));
    end
    req_valid = 1'b0;
    step(acc);
    chk("mf_valid_before", 64'(rsp_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mf_valid_in_rst", 64'(rsp_valid), 64'(0));
    chk("mf_ready_in_rst", 64'(req_ready), 64'(0));
    exp_q.delete();
    mtag = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mf_ready_after", 64'(req_ready), 64'(1));
    req_a = 32'd10; req_b = 32'd4; req_op = 3'b001; req_valid = 1'b1;
    step(acc);
    req_valid = 1'b0;
    step(acc);
    chk("mf_tag0", 64'(rsp_tag), 64'(0));
    chk("mf_data", 64'(rsp_data), 64'(6));
    drain();

    // Full with simultaneous pop and push
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_rand_req();
      step(acc);
      chk("full_fill_acc", 64'(acc), 64'(1));
    end
    set_rand_req();
    chk("full_ready_low", 64'(req_ready), 64'(0));
    chk("full_count3", 64'(dut.count_q), 64'(3));
    rsp_ready = 1'b1;
    step(acc);
    chk("full_no_acc", 64'(acc), 64'(0));
    chk("full_count_steady", 64'(dut.count_q), 64'(3));
    chk("full_ready_back", 64'(req_ready), 64'(1));
    step(acc);
    chk("full_acc_after", 64'(acc), 64'(1));
    drain();

    // Random traffic with random backpressure; operands held until accepted
    do_reset();
    acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (acc || !req_valid) begin
        req_valid = ($urandom_range(0, 3) != 0);
        set_rand_req();
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      step(acc);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of result FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter TAG_W, default 8: width of the request sequence tag.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: request operands valid.
REQ-006 SHALL have port req_ready, output, 1: block can accept a request this cycle.
REQ-007 SHALL have port req_a, input, 32: operand A.
REQ-008 SHALL have port req_b, input, 32: operand B.
REQ-009 SHALL have port req_op, input, 3: ALU control code.
REQ-010 SHALL have port rsp_valid, output, 1: result at FIFO head valid.
REQ-011 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port rsp_data, output, 32: ALU result.
REQ-013 SHALL have port rsp_cout, output, 1: ALU carry-out.
REQ-014 SHALL have port rsp_tag, output, TAG_W: sequence number of the request that produced the result.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid && req_ready; operands, op and the current tag are captured into a single stage-1 register and s1_valid is set.
REQ-016 SHALL compute rsp_data/rsp_cout combinationally from stage-1 contents via the alu sub-module; on the next edge the result, cout and tag SHALL be pushed into the FIFO and s1_valid SHALL be cleared, unless a new request is accepted on the same edge.
REQ-017 Latency SHALL be exactly 2 edges: request accepted at edge N -> rsp_valid high after edge N+1 when the FIFO was empty.
REQ-018 req_ready SHALL be (s1_valid + fifo_count) < DEPTH, registered-state only, with no combinational path from rsp_ready or req_valid.
REQ-019 A response SHALL be popped on an edge where rsp_valid && rsp_ready; rsp_data/rsp_cout/rsp_tag SHALL hold stable while rsp_valid && !rsp_ready.
REQ-020 Simultaneous push and pop in one edge SHALL leave fifo_count unchanged and be legal at both full and empty (at empty, pop is ignored because rsp_valid is low).
REQ-021 Results SHALL be returned in acceptance order; no request SHALL be dropped or duplicated.
REQ-022 Tag counter SHALL increment by 1 per accepted request and wrap from 2^TAG_W-1 to 0.
REQ-023 FIFO read/write pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH.
REQ-024 req_valid without req_ready SHALL have no effect; requester holds operands until accepted.

Reset
REQ-025 While rst_n is low: req_ready=0, rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_tag=0, s1_valid=0, fifo_count=0, pointers=0, tag counter=0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight and buffered results immediately; the first request accepted after release SHALL carry tag 0.
REQ-027 req_ready SHALL go high on the first rising edge after rst_n deasserts.

Structure
REQ-028 Op codes (ALU_ADD = 3'b000 and remaining codes), DEPTH and TAG_W defaults SHALL live in shared package alu_pkg.
REQ-029 The existing combinational alu module (ports a, b, control, dout, cout) SHALL be instantiated once as the only sub-module; FIFO SHALL be inline.

Verification
REQ-030 Single ADD: a=0x00000005, b=0x00000003, op=000, rsp_ready=1 -> two edges later rsp_data=0x00000008, rsp_cout=0, rsp_tag=0.
REQ-031 Carry: a=0xFFFFFFFF, b=0x00000001, op=000 -> rsp_data=0x00000000, rsp_cout=1.
REQ-032 Backpressure: rsp_ready=0, req_valid held for 6 ADD requests a=1..6, b=0 -> exactly 4 accepted, req_ready low; then rsp_ready=1 -> data 1,2,3,4 with tags 0..3 in order, then req_ready high.
REQ-033 Full-rate: rsp_ready=1, 300 back-to-back requests -> one accept per edge sustained, tags 0..255 then 0..43, order preserved.
REQ-034 Reset mid-flight: 3 requests accepted, rsp_ready=0, rst_n pulsed low -> rsp_valid=0 immediately; next request returns tag 0.
REQ-035 Full with simultaneous pop/push: FIFO at DEPTH-1 plus s1 valid, rsp_ready=1 -> fifo_count steady, no loss, req_ready reasserts next cycle.
